cdb_broadcast: RTL and testbench

Completion-stage arbiter that collects finished results from the eight function units and drives the 3-wide common data bus tag/value broadcast. The RS uses the broadcast to wake up operands, and the physical register file uses it for writeback. Each FU has a one-entry completion buffer. The block grants up to three buffered results per cycle in round-robin order. It also produces the per-FU ready bits that the RS uses to decide issue, so a full, un-granted buffer back-pressures its FU.

---
 rtl/cdb_broadcast.sv | 111 +++++++++++
 tb/tb_cdb_broadcast.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_broadcast.sv
// cdb_broadcast
//   Completion-stage arbiter. Each of NFU function units owns a one-entry
//   completion buffer; up to three buffered results per cycle are granted
//   in round-robin order onto the 3-wide common data bus (tag + value).
//
// Ports
//   clock       rising-edge clock
//   reset       asynchronous, active-low
//   squash      synchronous flush (branch mispredict)
//   fu_done     per-FU: a finished result is presented this cycle
//   fu_dest_pr  per-FU destination physical tag, packed NFU x PRW
//   fu_value    per-FU result value, packed NFU x XLEN
//   fu_ready    per-FU: buffer can take a result this cycle
//   cdb_valid   per-slot broadcast valid (3 slots)
//   cdb_t       per-slot broadcast tag, packed 3 x PRW, 0 when invalid
//   cdb_value   per-slot broadcast value, packed 3 x XLEN, 0 when invalid
module cdb_broadcast #(
  parameter int PRW  = 6,
  parameter int XLEN = 32,
  parameter int NFU  = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  squash,
  input  logic [NFU-1:0]        fu_done,
  input  logic [NFU*PRW-1:0]    fu_dest_pr,
  input  logic [NFU*XLEN-1:0]   fu_value,
  output logic [NFU-1:0]        fu_ready,
  output logic [2:0]            cdb_valid,
  output logic [3*PRW-1:0]      cdb_t,
  output logic [3*XLEN-1:0]     cdb_value
);

  localparam int NSLOT = 3;
  localparam int PTRW  = $clog2(NFU);

  logic [NFU-1:0]  buf_valid;
  logic [PRW-1:0]  buf_tag [NFU];
  logic [XLEN-1:0] buf_val [NFU];
  logic [PTRW-1:0] ptr;
  logic [PTRW-1:0] ptr_nxt;

  logic [NFU-1:0]  grant;
  logic [NSLOT-1:0] slot_vld;
  logic [PTRW-1:0] slot_idx [NSLOT];
  logic [PTRW-1:0] scan_idx;
  logic [1:0]      slot_cnt;
  logic [NFU-1:0]  capture;

  // Scan ptr, ptr+1, ... (mod NFU); the first three valid buffers fill
  // slots 0..2 in scan order. ptr_nxt follows the last winner.
  always_comb begin
    grant    = '0;
    slot_vld = '0;
    for (int unsigned k = 0; k < NSLOT; k++) slot_idx[k] = '0;
    ptr_nxt  = ptr;
    slot_cnt = '0;
    scan_idx = '0;
    for (int unsigned k = 0; k < NFU; k++) begin
      scan_idx = PTRW'((32'(ptr) + k) % NFU);
      if (buf_valid[scan_idx] && slot_cnt != 2'd3) begin
        grant[scan_idx]    = 1'b1;
        slot_vld[slot_cnt] = 1'b1;
        slot_idx[slot_cnt] = scan_idx;
        slot_cnt           = slot_cnt + 2'd1;
        ptr_nxt            = (scan_idx == PTRW'(NFU - 1)) ? '0 : scan_idx + 1'b1;
      end
    end
  end

  // A buffer draining this cycle can be refilled at the same edge.
  assign fu_ready = ~buf_valid | grant;
  assign capture  = fu_done & fu_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      buf_valid <= '0;
      ptr       <= '0;
      cdb_valid <= '0;
      cdb_t     <= '0;
      cdb_value <= '0;
      for (int unsigned i = 0; i < NFU; i++) begin
        buf_tag[i] <= '0;
        buf_val[i] <= '0;
      end
    end else if (squash) begin
      buf_valid <= '0;
      ptr       <= '0;
      cdb_valid <= '0;
      cdb_t     <= '0;
      cdb_value <= '0;
    end else begin
      for (int unsigned i = 0; i < NFU; i++) begin
        if (capture[i]) begin
          buf_valid[i] <= 1'b1;
          buf_tag[i]   <= fu_dest_pr[i*PRW +: PRW];
          buf_val[i]   <= fu_value[i*XLEN +: XLEN];
        end else if (grant[i]) begin
          buf_valid[i] <= 1'b0;
        end
      end
      ptr       <= ptr_nxt;
      cdb_valid <= slot_vld;
      for (int unsigned k = 0; k < NSLOT; k++) begin
        cdb_t[k*PRW +: PRW]     <= slot_vld[k] ? buf_tag[slot_idx[k]] : '0;
        cdb_value[k*XLEN +: XLEN] <= slot_vld[k] ? buf_val[slot_idx[k]] : '0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_broadcast.sv
module tb_cdb_broadcast;
  localparam int PRW  = 6;
  localparam int XLEN = 32;
  localparam int NFU  = 8;

  logic                clock = 1'b0;
  logic                reset;
  logic                squash;
  logic [NFU-1:0]      fu_done;
  logic [NFU*PRW-1:0]  fu_dest_pr;
  logic [NFU*XLEN-1:0] fu_value;
  logic [NFU-1:0]      fu_ready;
  logic [2:0]          cdb_valid;
  logic [3*PRW-1:0]    cdb_t;
  logic [3*XLEN-1:0]   cdb_value;

  always #5 clock = ~clock;

  cdb_broadcast #(.PRW(PRW), .XLEN(XLEN), .NFU(NFU)) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .fu_done(fu_done), .fu_dest_pr(fu_dest_pr), .fu_value(fu_value),
    .fu_ready(fu_ready), .cdb_valid(cdb_valid), .cdb_t(cdb_t),
    .cdb_value(cdb_value)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Reference model: buffers as plain arrays, pointer as an integer,
  // registered bus contents as per-slot arrays.
  bit              m_bv   [NFU];
  logic [PRW-1:0]  m_bt   [NFU];
  logic [XLEN-1:0] m_bval [NFU];
  int              m_ptr;
  bit              m_cv   [3];
  logic [PRW-1:0]  m_ct   [3];
  logic [XLEN-1:0] m_cval [3];

  function automatic void m_reset();
    for (int i = 0; i < NFU; i++) begin
      m_bv[i] = 0; m_bt[i] = '0; m_bval[i] = '0;
    end
    for (int k = 0; k < 3; k++) begin
      m_cv[k] = 0; m_ct[k] = '0; m_cval[k] = '0;
    end
    m_ptr = 0;
  endfunction

  typedef int iq_t[$];

  function automatic iq_t winners();
    iq_t q;
    for (int k = 0; k < NFU; k++) begin
      int i = (m_ptr + k) % NFU;
      if (m_bv[i] && q.size() < 3) q.push_back(i);
    end
    return q;
  endfunction

  function automatic bit in_q(iq_t q, int i);
    foreach (q[j]) if (q[j] == i) return 1;
    return 0;
  endfunction

  // Checks outputs at the falling edge, advances the model over the next
  // rising edge, and returns 1 time unit after it.
  task automatic cycle();
    iq_t q;
    logic [NFU-1:0]    rdy;
    logic [2:0]        ev;
    logic [3*PRW-1:0]  et;
    logic [3*XLEN-1:0] evl;
    bit              n_bv [NFU];
    logic [PRW-1:0]  n_bt [NFU];
    logic [XLEN-1:0] n_bval [NFU];
    int              n_ptr;
    bit              n_cv [3];
    logic [PRW-1:0]  n_ct [3];
    logic [XLEN-1:0] n_cval [3];
    @(negedge clock);
    q = winners();
    for (int i = 0; i < NFU; i++) rdy[i] = !m_bv[i] || in_q(q, i);
    for (int k = 0; k < 3; k++) begin
      ev[k] = m_cv[k];
      et[k*PRW +: PRW] = m_ct[k];
      evl[k*XLEN +: XLEN] = m_cval[k];
    end
    check_eq("fu_ready", fu_ready, rdy);
    check_eq("cdb_valid", cdb_valid, ev);
    check_eq("cdb_t", cdb_t, et);
    check_eq("cdb_value", cdb_value, evl);
    n_bv = m_bv; n_bt = m_bt; n_bval = m_bval; n_ptr = m_ptr;
    if (squash) begin
      for (int i = 0; i < NFU; i++) n_bv[i] = 0;
      for (int k = 0; k < 3; k++) begin
        n_cv[k] = 0; n_ct[k] = '0; n_cval[k] = '0;
      end
      n_ptr = 0;
    end else begin
      for (int i = 0; i < NFU; i++) begin
        if (fu_done[i] && rdy[i]) begin
          n_bv[i] = 1;
          n_bt[i] = fu_dest_pr[i*PRW +: PRW];
          n_bval[i] = fu_value[i*XLEN +: XLEN];
        end else if (in_q(q, i)) begin
          n_bv[i] = 0;
        end
      end
      for (int k = 0; k < 3; k++) begin
        n_cv[k]   = k < q.size();
        n_ct[k]   = (k < q.size()) ? m_bt[q[k]] : '0;
        n_cval[k] = (k < q.size()) ? m_bval[q[k]] : '0;
      end
      if (q.size() > 0) n_ptr = (q[q.size()-1] + 1) % NFU;
    end
    @(posedge clock);
    #1;
    m_bv = n_bv; m_bt = n_bt; m_bval = n_bval; m_ptr = n_ptr;
    m_cv = n_cv; m_ct = n_ct; m_cval = n_cval;
  endtask

  task automatic idle();
    fu_done = '0;
    squash  = 1'b0;
  endtask

  task automatic set_done(input int i, input logic [PRW-1:0] tag, input logic [XLEN-1:0] val);
    fu_done[i] = 1'b1;
    fu_dest_pr[i*PRW +: PRW] = tag;
    fu_value[i*XLEN +: XLEN] = val;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    fu_dest_pr = '0;
    fu_value = '0;
    idle();
    m_reset();
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_ready", fu_ready, 8'hFF);
    check_eq("rst_valid", cdb_valid, 3'b000);
    check_eq("rst_t", cdb_t, '0);
    check_eq("rst_value", cdb_value, '0);
    reset = 1'b1;
    repeat (3) cycle();

    // Single result from FU 5
    set_done(5, 6'h2A, 32'h1234);
    cycle();
    idle();
    cycle();
    check_eq("single_valid", cdb_valid, 3'b001);
    check_eq("single_t0", cdb_t[PRW-1:0], 6'h2A);
    check_eq("single_v0", cdb_value[XLEN-1:0], 32'h1234);
    cycle();
    check_eq("single_gone", cdb_valid, 3'b000);

    // Wrap-around from ptr 6 with back-to-back refill of FU 6
    set_done(6, 6'h16, 32'h606); set_done(7, 6'h17, 32'h707);
    set_done(0, 6'h10, 32'h000); set_done(1, 6'h11, 32'h101);
    cycle();
    idle();
    check_eq("wrap_ready", fu_ready, 8'hFD);
    set_done(6, 6'h26, 32'h6060);
    cycle();
    idle();
    check_eq("wrap_valid", cdb_valid, 3'b111);
    check_eq("wrap_t", cdb_t, {6'h10, 6'h17, 6'h16});
    cycle();
    check_eq("wrap_next_valid", cdb_valid, 3'b011);
    check_eq("wrap_next_t", cdb_t, {6'h00, 6'h26, 6'h11});
    repeat (2) cycle();

    // Squash with four buffers valid and two new dones
    for (int i = 0; i < 4; i++) set_done(i, 6'(6'h30 + i), 32'(32'hA0 + i));
    cycle();
    idle();
    squash = 1'b1;
    set_done(4, 6'h34, 32'hA4); set_done(5, 6'h35, 32'hA5);
    cycle();
    idle();
    check_eq("squash_valid", cdb_valid, 3'b000);
    check_eq("squash_ready", fu_ready, 8'hFF);
    repeat (3) cycle();

    // Saturation: all eight FUs at once
    for (int i = 0; i < NFU; i++) set_done(i, 6'(i + 1), 32'(32'h100 + i));
    cycle();
    idle();
    check_eq("sat_ready1", fu_ready, 8'h07);
    cycle();
    check_eq("sat_t1", cdb_t, {6'd3, 6'd2, 6'd1});
    check_eq("sat_ready2", fu_ready, 8'h3F);
    cycle();
    check_eq("sat_t2", cdb_t, {6'd6, 6'd5, 6'd4});
    cycle();
    check_eq("sat_valid3", cdb_valid, 3'b011);
    check_eq("sat_t3", cdb_t, {6'd0, 6'd8, 6'd7});
    cycle();

    // Asynchronous reset mid-cycle while the bus is valid
    set_done(2, 6'h33, 32'hCAFE);
    cycle();
    idle();
    set_done(3, 6'h3C, 32'hBEEF);
    cycle();
    idle();
    check_eq("pre_reset_valid", cdb_valid, 3'b001);
    #2;
    reset = 1'b0;
    #1;
    check_eq("areset_valid", cdb_valid, 3'b000);
    check_eq("areset_t", cdb_t, '0);
    check_eq("areset_value", cdb_value, '0);
    check_eq("areset_ready", fu_ready, 8'hFF);
    m_reset();
    #3;
    reset = 1'b1;
    repeat (4) cycle();

    // Randomized traffic, including protocol violations and squashes
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NFU; i++) begin
        fu_done[i] = ($urandom_range(0, 99) < 45);
        fu_dest_pr[i*PRW +: PRW] = 6'($urandom_range(1, 63));
        fu_value[i*XLEN +: XLEN] = $urandom;
      end
      squash = ($urandom_range(0, 29) == 0);
      cycle();
    end
    idle();
    repeat (4) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
